// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, PC redirect and flush.
// Build option: define EX_MEM_SKID_EN for a two-entry skid buffer with registered in_ready.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_r,
    input  logic [3:0]  alu_flags,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  ctrl,
    input  logic [2:0]  funct3,
    input  logic [31:0] br_target,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic [31:0] out_rs2,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_ctrl,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] rs2;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t            in_entry_c;
    entry_t            main_q, main_d;
    logic              main_valid_q, main_valid_d;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              cond_true_c;
    logic              taken_c;
    logic              accept_c;
    logic              drain_c;

    // Flags arrive as {cf, zf, vf, sf}; branch/jump bits stop here.
    assign in_entry_c = '{r: alu_r, rs2: rs2_data, rd: rd_addr, ctrl: ctrl[4:2]};

    always_comb begin
        cond_true_c = 1'b0;
        case (funct3)
            3'b000:  cond_true_c = alu_flags[2];
            3'b001:  cond_true_c = ~alu_flags[2];
            3'b100:  cond_true_c = alu_flags[0] ^ alu_flags[1];
            3'b101:  cond_true_c = ~(alu_flags[0] ^ alu_flags[1]);
            3'b110:  cond_true_c = ~alu_flags[3];
            3'b111:  cond_true_c = alu_flags[3];
            default: cond_true_c = 1'b0;
        endcase
    end

    assign taken_c  = ctrl[0] | (ctrl[1] & cond_true_c);
    assign accept_c = in_valid & in_ready;
    assign drain_c  = main_valid_q & out_ready;

`ifdef EX_MEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    assign in_ready = ~skid_valid_q;

    // Skid refills main first so ordering stays FIFO.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain_c) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept_c;
                if (accept_c) begin
                    skid_d = in_entry_c;
                end
            end else begin
                main_valid_d = accept_c;
                if (accept_c) begin
                    main_d = in_entry_c;
                end
            end
        end else if (accept_c) begin
            skid_d       = in_entry_c;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = ~main_valid_q | out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (!main_valid_q || drain_c) begin
            main_valid_d = accept_c;
            if (accept_c) begin
                main_d = in_entry_c;
            end
        end
    end
`endif

    // One-cycle redirect pulse; a flush kills the same-cycle taken input.
    always_comb begin
        redirect_d    = accept_c & taken_c & ~flush;
        redirect_pc_d = redirect_pc_q;
        if (redirect_d) begin
            redirect_pc_d = br_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q        <= '0;
            main_valid_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            main_q        <= main_d;
            main_valid_q  <= main_valid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_r       = main_q.r;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_ctrl    = main_q.ctrl;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (default or EX_MEM_SKID_EN build).
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_r;
    logic [3:0]  alu_flags;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic [4:0]  ctrl;
    logic [2:0]  funct3;
    logic [31:0] br_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_ctrl;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    ex_mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_r       (alu_r),
        .alu_flags   (alu_flags),
        .rs2_data    (rs2_data),
        .rd_addr     (rd_addr),
        .ctrl        (ctrl),
        .funct3      (funct3),
        .br_target   (br_target),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_ctrl    (out_ctrl),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        alu_r     = '0;
        alu_flags = '0;
        rs2_data  = '0;
        rd_addr   = '0;
        ctrl      = '0;
        funct3    = '0;
        br_target = '0;
        flush     = 1'b0;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [4:0] c, input logic [2:0] f3, input logic [3:0] fl,
                        input logic [31:0] tgt);
        in_valid  = 1'b1;
        alu_r     = r;
        rs2_data  = rs2;
        rd_addr   = rd;
        ctrl      = c;
        funct3    = f3;
        alu_flags = fl;
        br_target = tgt;
    endtask

    // Branch condition table: flags are {cf, zf, vf, sf}; ctrl is {rw, mr, mw, br, jmp}.
    logic [2:0] t_f3   [10];
    logic [3:0] t_fl   [10];
    logic [4:0] t_ctrl [10];
    logic       t_exp  [10];

    initial begin
        t_f3[0] = 3'b110; t_fl[0] = 4'b0000; t_ctrl[0] = 5'b00010; t_exp[0] = 1'b1;
        t_f3[1] = 3'b101; t_fl[1] = 4'b0011; t_ctrl[1] = 5'b00010; t_exp[1] = 1'b1;
        t_f3[2] = 3'b100; t_fl[2] = 4'b0011; t_ctrl[2] = 5'b00010; t_exp[2] = 1'b0;
        t_f3[3] = 3'b111; t_fl[3] = 4'b1000; t_ctrl[3] = 5'b00010; t_exp[3] = 1'b1;
        t_f3[4] = 3'b010; t_fl[4] = 4'b1111; t_ctrl[4] = 5'b00010; t_exp[4] = 1'b0;
        t_f3[5] = 3'b011; t_fl[5] = 4'b0000; t_ctrl[5] = 5'b00010; t_exp[5] = 1'b0;
        t_f3[6] = 3'b100; t_fl[6] = 4'b0001; t_ctrl[6] = 5'b00010; t_exp[6] = 1'b1;
        t_f3[7] = 3'b001; t_fl[7] = 4'b0000; t_ctrl[7] = 5'b00010; t_exp[7] = 1'b1;
        t_f3[8] = 3'b010; t_fl[8] = 4'b0000; t_ctrl[8] = 5'b00001; t_exp[8] = 1'b1;
        t_f3[9] = 3'b000; t_fl[9] = 4'b0100; t_ctrl[9] = 5'b10000; t_exp[9] = 1'b0;
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();

        // Asynchronous reset values before any clock edge
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_out_r", out_r, 32'd0);
        check("rst_out_rs2", out_rs2, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        tick();
        rst = 1'b0;

        // Simple register-write transaction, one cycle latency
        send(32'h0000_0010, 32'h0000_00AA, 5'd5, 5'b10000, 3'b000, 4'b0000, 32'h0);
        tick();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_r", out_r, 32'h10);
        check("basic_rs2", out_rs2, 32'hAA);
        check("basic_rd", 32'(out_rd), 32'd5);
        check("basic_ctrl", 32'(out_ctrl), 32'b100);
        check("basic_no_redirect", 32'(redirect), 32'd0);
        idle_inputs();
        tick();
        check("basic_drained", 32'(out_valid), 32'd0);

        // BEQ taken, then BNE with the same flags not taken
        send(32'h0, 32'h0, 5'd0, 5'b00010, 3'b000, 4'b0100, 32'h0000_0100);
        tick();
        check("beq_redirect", 32'(redirect), 32'd1);
        check("beq_pc", redirect_pc, 32'h100);
        check("beq_ctrl_stripped", 32'(out_ctrl), 32'd0);
        idle_inputs();
        tick();
        check("beq_pulse_end", 32'(redirect), 32'd0);
        send(32'h0, 32'h0, 5'd0, 5'b00010, 3'b001, 4'b0100, 32'h0000_0200);
        tick();
        check("bne_no_redirect", 32'(redirect), 32'd0);
        idle_inputs();
        tick();

        for (int i = 0; i < 10; i++) begin
            send(32'h0, 32'h0, 5'd1, t_ctrl[i], t_f3[i], t_fl[i], 32'h1000 + 32'(i * 4));
            tick();
            check($sformatf("cond%0d_redirect", i), 32'(redirect), 32'(t_exp[i]));
            if (t_exp[i]) check($sformatf("cond%0d_pc", i), redirect_pc, 32'h1000 + 32'(i * 4));
            idle_inputs();
            tick();
            check($sformatf("cond%0d_pulse_end", i), 32'(redirect), 32'd0);
        end

        // Back-pressure: A then B, no loss or duplication
        out_ready = 1'b0;
        send(32'h0000_000A, 32'h0, 5'd10, 5'b10000, 3'b000, 4'b0000, 32'h0);
        tick();
        check("bp_a_valid", 32'(out_valid), 32'd1);
        check("bp_a_r", out_r, 32'hA);
        send(32'h0000_000B, 32'h0, 5'd11, 5'b10000, 3'b000, 4'b0000, 32'h0);
`ifdef EX_MEM_SKID_EN
        check("bp_ready_before_b", 32'(in_ready), 32'd1);
        tick();
        check("bp_ready_after_b", 32'(in_ready), 32'd0);
        check("bp_hold_r", out_r, 32'hA);
        idle_inputs();
        tick();
        check("bp_stall_r", out_r, 32'hA);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_r", out_r, 32'hB);
        check("bp_b_rd", 32'(out_rd), 32'd11);
        check("bp_ready_again", 32'(in_ready), 32'd1);
`else
        check("bp_ready_full", 32'(in_ready), 32'd0);
        tick();
        check("bp_hold_r", out_r, 32'hA);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_drain", 32'(in_ready), 32'd1);
        tick();
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_r", out_r, 32'hB);
        check("bp_b_rd", 32'(out_rd), 32'd11);
        idle_inputs();
`endif
        idle_inputs();
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with held entries and a same-cycle taken jump
        out_ready = 1'b0;
        send(32'h0000_00C1, 32'h0, 5'd1, 5'b10000, 3'b000, 4'b0000, 32'h0);
        tick();
`ifdef EX_MEM_SKID_EN
        send(32'h0000_00C2, 32'h0, 5'd2, 5'b10000, 3'b000, 4'b0000, 32'h0);
        tick();
        check("fl_full", 32'(in_ready), 32'd0);
`endif
        send(32'h0, 32'h0, 5'd3, 5'b10001, 3'b010, 4'b0000, 32'h0000_0300);
        flush = 1'b1;
        tick();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_redirect", 32'(redirect), 32'd0);
        idle_inputs();
        tick();
        check("fl_after_valid", 32'(out_valid), 32'd0);
        check("fl_after_redirect", 32'(redirect), 32'd0);

        // Flush on an empty stage drops an acceptable taken jump
        out_ready = 1'b1;
        send(32'h0, 32'h0, 5'd4, 5'b10001, 3'b010, 4'b0000, 32'h0000_0340);
        flush = 1'b1;
        tick();
        check("fle_valid", 32'(out_valid), 32'd0);
        check("fle_redirect", 32'(redirect), 32'd0);
        idle_inputs();

        // A redirect already registered survives a flush in its cycle
        send(32'h0, 32'h0, 5'd4, 5'b00001, 3'b000, 4'b0000, 32'h0000_0500);
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        check("fl25_redirect", 32'(redirect), 32'd1);
        check("fl25_pc", redirect_pc, 32'h500);
        tick();
        check("fl25_end", 32'(redirect), 32'd0);
        check("fl25_valid", 32'(out_valid), 32'd0);
        idle_inputs();

        // Reset mid-operation clears everything before the next edge
        out_ready = 1'b0;
        send(32'h0000_0055, 32'h0000_0066, 5'd7, 5'b11001, 3'b000, 4'b0000, 32'h0000_0400);
        tick();
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_redirect", 32'(redirect), 32'd1);
        check("mid_ctrl", 32'(out_ctrl), 32'b110);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_redirect", 32'(redirect), 32'd0);
        check("mrst_pc", redirect_pc, 32'd0);
        check("mrst_r", out_r, 32'd0);
        check("mrst_rs2", out_rs2, 32'd0);
        check("mrst_rd", 32'(out_rd), 32'd0);
        check("mrst_ctrl", 32'(out_ctrl), 32'd0);
        #1;
        rst = 1'b0;
        send(32'h0000_0077, 32'h0, 5'd9, 5'b10000, 3'b000, 4'b0000, 32'h0);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_r", out_r, 32'h77);
        check("post_rst_redirect", 32'(redirect), 32'd0);
        idle_inputs();
        out_ready = 1'b1;
        tick();
        check("post_rst_drain", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
